// File: rtl/uart_tx_launch_fifo.sv
// Byte FIFO feeding the TX bit-select stage: pops one byte into a held register,
// pulses tx_en, and waits for tx_done before launching the next frame.
module uart_tx_launch_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tx_done,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              launch_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign count       = count_q;
  assign tx_data     = tx_data_q;
  assign overflow    = overflow_q;
  assign tx_en       = (state_q == LAUNCH);
  assign launch_busy = (state_q != IDLE);

  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;

    case (state_q)
      IDLE:      pop = !empty;
      WAIT_DONE: pop = tx_done && !empty;
      default:   pop = 1'b0;
    endcase

    // A pop frees a slot this cycle, so a write while full still lands.
    push       = wr_en && (!full || pop);
    overflow_d = wr_en && full && !pop;

    case (state_q)
      IDLE:      if (pop) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = pop ? LAUNCH : IDLE;
      default:   state_d = IDLE;
    endcase

    if (pop) begin
      tx_data_d = mem[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (reset) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tx_data_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_launch_fifo.sv
// Randomised and directed bench for uart_tx_launch_fifo, checked every cycle
// against a queue-based model of the launch/done protocol.
module tb_uart_tx_launch_fifo;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       launch_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  uart_tx_launch_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .areset_n(areset_n), .reset(reset), .wr_en(wr_en),
    .wr_data(wr_data), .tx_done(tx_done), .tx_en(tx_en), .tx_data(tx_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .launch_busy(launch_busy)
  );

  always #5 clk = ~clk;

  // Model: a queue of waiting bytes plus a phase
  // (0 = nothing in flight, 1 = launch cycle, 2 = awaiting done).
  logic [7:0] mq[$];
  int         ph = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  bit         m_pop;
  bit         m_full;

  always @(posedge clk or negedge areset_n) begin
    if (!areset_n || reset) begin
      mq.delete();
      ph = 0;
      m_data = 8'h00;
      m_ovf = 1'b0;
    end else begin
      m_full = (mq.size() == 16);
      m_pop = (mq.size() != 0) && (ph == 0 || (ph == 2 && tx_done));
      m_ovf = wr_en && m_full && !m_pop;
      if (m_pop) begin
        m_data = mq.pop_front();
        ph = 1;
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2 && tx_done) begin
        ph = 0;
      end
      if (wr_en && (!m_full || m_pop)) mq.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("tx_en", int'(tx_en), int'(ph == 1));
      chk("tx_data", int'(tx_data), int'(m_data));
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == 16));
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("launch_busy", int'(launch_busy), int'(ph != 0));
    end
  end

  logic [7:0] launched[$];
  always @(negedge clk) begin
    if (tx_en) launched.push_back(tx_data);
  end

  // Apply inputs at a negedge and hold them for one cycle.
  task automatic step(input bit w, input logic [7:0] d, input bit dn, input bit rs);
    wr_en = w;
    wr_data = d;
    tx_done = dn;
    reset = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((!empty || launch_busy) && n < 2000) begin
      step(1'b0, 8'h00, (n % 3) == 2, 1'b0);
      n++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk({name, "_drained"}, int'(launch_busy || !empty), 0);
  endtask

  logic [7:0] exp_seq[$];
  int pulses;

  initial begin
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    cmp_on = 1'b1;
    idle(2);
    chk("reset_empty", int'(empty), 1);
    chk("reset_count", int'(count), 0);

    // Async reset while waiting on done with three bytes queued.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    idle(4);
    chk("pre_rst_count", int'(count), 3);
    #2 areset_n = 1'b0;
    #1;
    chk("arst_tx_en", int'(tx_en), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_busy", int'(launch_busy), 0);
    @(negedge clk);
    areset_n = 1'b1;
    launched.delete();
    idle(100);
    chk("post_rst_launches", launched.size(), 0);

    // Single byte: launch two cycles after the write.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("single_tx_en", int'(tx_en), 1);
    chk("single_tx_data", int'(tx_data), 8'hA5);
    chk("single_count", int'(count), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("single_pulse_width", int'(tx_en), 0);
    idle(196);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_done_busy", int'(launch_busy), 0);
    chk("single_done_empty", int'(empty), 1);
    launched.delete();
    idle(20);
    chk("single_no_relaunch", launched.size(), 0);

    // Back-to-back frames, one launch per done.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      idle(159);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (p < 2) begin
        chk("b2b_tx_en", int'(tx_en), 1);
        chk("b2b_tx_data", int'(tx_data), p == 0 ? 8'h22 : 8'h33);
      end else begin
        chk("b2b_idle", int'(launch_busy), 0);
      end
    end
    chk("b2b_launches", launched.size(), 3);
    if (launched.size() == 3) begin
      chk("b2b_seq0", int'(launched[0]), 8'h11);
      chk("b2b_seq1", int'(launched[1]), 8'h22);
      chk("b2b_seq2", int'(launched[2]), 8'h33);
    end

    // Fill to full, overflow, then simultaneous push/pop at full.
    launched.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_count", int'(count), 16);
    chk("fill_full", int'(full), 1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_one_cycle", int'(overflow), 0);
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    chk("pushpop_ovf", int'(overflow), 0);
    chk("pushpop_count", int'(count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain("full");
    exp_seq.delete();
    for (int i = 0; i <= 16; i++) exp_seq.push_back(8'(i));
    exp_seq.push_back(8'h7E);
    chk("full_launches", launched.size(), exp_seq.size());
    if (launched.size() == exp_seq.size())
      foreach (exp_seq[i]) chk("full_seq", int'(launched[i]), int'(exp_seq[i]));

    // Stream 40 random bytes with random done pulses (pointers wrap twice).
    launched.delete();
    exp_seq.delete();
    pulses = 0;
    while (exp_seq.size() < 40 && pulses < 5000) begin
      if (!full && $urandom_range(0, 1) == 1) begin
        wr_data = 8'($urandom);
        exp_seq.push_back(wr_data);
        step(1'b1, wr_data, $urandom_range(0, 3) == 0, 1'b0);
      end else begin
        step(1'b0, 8'h00, $urandom_range(0, 3) == 0, 1'b0);
      end
      pulses++;
    end
    drain("stream");
    chk("stream_launches", launched.size(), 40);
    if (launched.size() == 40)
      foreach (exp_seq[i]) chk("stream_seq", int'(launched[i]), int'(exp_seq[i]));

    // Unconstrained random traffic including writes while full.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 5) == 0, 1'b0);

    // Sync reset with bytes queued, then a fresh launch.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("srst_count", int'(count), 0);
    chk("srst_busy", int'(launch_busy), 0);
    chk("srst_tx_data", int'(tx_data), 0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("srst_relaunch_en", int'(tx_en), 1);
    chk("srst_relaunch_data", int'(tx_data), 8'h5A);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_launch_fifo.md
Name: uart_tx_launch_fifo

Overview:
- Byte-buffering launch controller that sits directly upstream of the TX bit-select/shift stage.
- Accepts bytes from the system side into a circular FIFO.
- Pops one byte at a time into a held frame-data register and issues a single-cycle tx_en pulse to the bit-select stage.
- Waits for that stage's done pulse before launching the next byte, so frames go back-to-back with no software handshake.

Parameters:
- DATA_W, 8, width of each queued byte and of tx_data.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (16 entries).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- areset_n  input  1  asynchronous active-low reset; clears all state.
- reset  input  1  synchronous clear, active-high; same effect as areset_n, applied at the clock edge.
- wr_en  input  1  write strobe; pushes wr_data when not full.
- wr_data  input  DATA_W  byte to enqueue.
- tx_done  input  1  one-cycle pulse from bit-select stage at the end of the stop bit.
- tx_en  output  1  one-cycle launch pulse to bit-select stage.
- tx_data  output  DATA_W  registered byte for the frame being sent; held stable from launch until the next pop.
- full  output  1  count == 2**ADDR_W.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  number of queued bytes, excluding the byte in flight.
- overflow  output  1  one-cycle pulse when wr_en arrives while full and no pop occurs that cycle.
- launch_busy  output  1  high in LAUNCH and WAIT_DONE.

Behaviour:
- Reset (async or sync):
  - wr_ptr, rd_ptr and count = 0; state = IDLE.
  - tx_en = 0, tx_data = 0, overflow = 0.
  - empty = 1, full = 0, launch_busy = 0.
  - FIFO storage is not cleared.
- A sync reset mid-frame abandons the frame. The bit-select stage is expected to receive the same reset, so no done is awaited.
- FIFO:
  - Storage is a DATA_W x 2**ADDR_W array.
  - Pointers are ADDR_W bits and wrap modulo depth.
  - Push when wr_en && (!full || pop).
  - pop is an internal one-cycle strobe.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - A push when full without a pop is dropped. The pointer does not move and overflow = 1 for that cycle.
  - A pop is only issued when !empty. A push into an empty FIFO is not readable the same cycle, so there is no fall-through.
- State machine, 3 states:
  - IDLE: if !empty then pop, tx_data <= mem[rd_ptr], go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_en = 1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: on tx_done:
    - If !empty then pop, load tx_data, go to LAUNCH (back-to-back).
    - Otherwise go to IDLE.
    - Without tx_done, stay.
- tx_done outside WAIT_DONE is ignored.
- tx_en and tx_data are registered. tx_en is decoded from a registered state, with no combinational path from any input.
- Latency:
  - Write at cycle 0 into an empty, idle block → pop at cycle 1 → tx_en high at cycle 2.
  - tx_done at cycle k (FIFO non-empty) → tx_data updated and tx_en high at cycle k+1. That lands on the cycle the bit-select stage is back in IDLE.
- tx_data changes only on a pop. It holds its value through IDLE after the final frame.
- count, full and empty are registered and reflect state after the current edge.

Test Plan:
1. Reset:
   - Stimulus: assert areset_n low mid-WAIT_DONE with count = 3.
   - Required response: immediately tx_en = 0, count = 0, empty = 1, launch_busy = 0. After release with no writes, no tx_en for 100 cycles.
2. Single byte:
   - Stimulus: write 0xA5 at cycle 0.
   - Required response: tx_data = 0xA5 and tx_en = 1 at cycle 2, for 1 cycle only. count stays 0. Pulse tx_done at cycle 200 → launch_busy = 0 and empty = 1 at cycle 201. No further tx_en.
3. Back-to-back:
   - Stimulus: write 0x11, 0x22, 0x33 on consecutive cycles, then pulse tx_done every 160 cycles.
   - Required response: tx_en occurs once per done, at done+1. tx_data sequence is 0x11, 0x22, 0x33. tx_data is stable between pulses.
4. Full/overflow:
   - Stimulus: hold tx_done low and write 18 bytes (0x00..0x11).
   - Required response:
     - The first byte is popped into flight, so count reaches 16 and full = 1 after the 17th write.
     - The 18th write (0x11) gives overflow = 1 for one cycle, and count stays 16.
     - Draining via tx_done yields 0x00..0x10 in order.
5. Simultaneous push/pop when full:
   - Stimulus: with count = 16, pulse tx_done and wr_en (0x7E) in the same cycle.
   - Required response: overflow = 0, count stays 16, and 0x7E is the last byte drained.
6. Sync reset and pointer wrap:
   - Stimulus: stream 40 bytes with interleaved done pulses so the pointers wrap twice, then assert reset for 1 cycle.
   - Required response: all 40 bytes are emitted in order. After the reset, count = 0 and the state is IDLE, and a new write 0x5A launches at write+2.
